// File: rtl/word_sequencer_if.sv
// +------------------------------------------------------------------+
// | word_sequencer_if : sequencer <-> word bank / datapath bundle    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

interface word_sequencer_if;
    logic        start;
    logic [3:0]  addr;
    logic [79:0] word;
    logic [3:0]  opr;
    logic [31:0] const_re;
    logic [31:0] const_im;
    logic        enrega;
    logic        enregb;
    logic        cnsta;
    logic        cnstb;
    logic        start_op;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic        busy;
    logic        done;
`ifdef WORD_SEQUENCER_STEP_EN
    logic        step;
`endif

    modport master (
`ifdef WORD_SEQUENCER_STEP_EN
        input  step,
`endif
        input  start, word,
        output addr, opr, const_re, const_im, enrega, enregb, cnsta, cnstb,
               start_op, wr_en, wr_addr, busy, done
    );

    modport slave (
`ifdef WORD_SEQUENCER_STEP_EN
        output step,
`endif
        output start, word,
        input  addr, opr, const_re, const_im, enrega, enregb, cnsta, cnstb,
               start_op, wr_en, wr_addr, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/word_sequencer.sv
// +------------------------------------------------------------------+
// | word_sequencer : fetches, decodes and times instruction words    |
// | FIRST..LAST; optional single-step via WORD_SEQUENCER_STEP_EN.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module word_sequencer #(
    parameter int FIRST = 0,
    parameter int LAST  = 15
) (
    input  wire               clock,
    input  wire               reset,
    word_sequencer_if.master  bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_WRITE = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;
`ifdef WORD_SEQUENCER_STEP_EN
    localparam logic [2:0] c_ST_PAUSE = 3'd6;
`endif

    localparam logic [3:0] c_FIRST = 4'(FIRST);
    localparam logic [3:0] c_LAST  = 4'(LAST);

    logic [2:0]  r_state;
    logic [3:0]  r_addr;
    logic [79:0] r_word;
    logic [5:0]  r_cnt;
    logic        r_start_op;
    logic        r_wr_en;
    logic        r_busy;
    logic        r_done;
    logic [5:0]  w_load;

    // A zero budget still spends one cycle in WAIT, same as a budget of one.
    assign w_load = (r_word[11:6] == 6'd0) ? 6'd1 : r_word[11:6];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= c_FIRST;
            r_word     <= 80'd0;
            r_cnt      <= 6'd0;
            r_start_op <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start_op <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_busy  <= 1'b1;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_word     <= bus.word;
                    r_start_op <= 1'b1;
                    r_state    <= c_ST_ISSUE;
                end
                c_ST_ISSUE: begin
                    r_cnt   <= w_load;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_wr_en <= 1'b1;
                        r_state <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    if (r_addr == c_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_addr  <= r_addr + 4'd1;
`ifdef WORD_SEQUENCER_STEP_EN
                        r_state <= c_ST_PAUSE;
`else
                        r_state <= c_ST_FETCH;
`endif
                    end
                end
                c_ST_DONE: begin
                    r_addr  <= c_FIRST;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
`ifdef WORD_SEQUENCER_STEP_EN
                c_ST_PAUSE: begin
                    if (bus.step) r_state <= c_ST_FETCH;
                end
`endif
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Decoded controls come straight from the latch so they hold between words.
    assign bus.addr     = r_addr;
    assign bus.const_re = r_word[79:48];
    assign bus.const_im = r_word[47:16];
    assign bus.opr      = r_word[15:12];
    assign bus.wr_addr  = r_word[5:4];
    assign bus.enrega   = r_word[3];
    assign bus.enregb   = r_word[2];
    assign bus.cnsta    = r_word[1];
    assign bus.cnstb    = r_word[0];
    assign bus.start_op = r_start_op;
    assign bus.wr_en    = r_wr_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

`default_nettype wire
